// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//   Each digit takes a hex nibble and a decimal point. Digits are scanned
//   one per slot of SCAN_DIV cycles. The first DEAD_CYCLES cycles of every
//   slot are blanked to suppress ghosting. New data is captured into a
//   pending register and reaches the display only at a frame boundary, so
//   a frame is never torn.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     defined   - leading zero digits (never digit 0) show no segments
//     undefined - every digit is decoded
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   value      hex nibbles, digit 0 = value[3:0]
//   dp_mask    decimal point request per digit, 1 = lit
//   load       strobe: capture value/dp_mask into the pending register
//   blank      level: force the display dark (1-cycle latency)
//   segments   {G,F,E,D,C,B,A}, active-low
//   dp_n       decimal point, active-low
//   digit_en   one-hot digit select, polarity per DIGIT_ACTIVE_LOW
//   frame_done one-cycle pulse with the first output cycle of a new frame
//
// State table
//   ST_GAP   | slot dead-time, all digits off
//   ST_DRIVE | current digit enabled with its decoded segments
module seg7_scan_driver #(
   parameter int NUM_DIGITS       = 4,
   parameter int SCAN_DIV         = 1000,
   parameter int DEAD_CYCLES      = 16,
   parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    load,
   input  logic                    blank,
   output logic [6:0]              segments,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]      CNT_DEAD = CNT_W'(DEAD_CYCLES);
   localparam logic [DIG_W-1:0]      DIG_MAX  = DIG_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

   typedef enum logic {ST_GAP = 1'b0, ST_DRIVE = 1'b1} state_t;

   // With no dead-time the scan starts straight in DRIVE.
   localparam state_t ST_RESET = (DEAD_CYCLES == 0) ? ST_DRIVE : ST_GAP;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIG_W-1:0]        dig_q, dig_d;
   state_t                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_flag_q, pend_flag_d;
   logic                    bnd_q, bnd_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
   logic                    frame_done_q, frame_done_d;

   logic                    wrap, frame_end;
   logic [3:0]              nib;
   logic                    dp_sel, lz_blank;
   logic [NUM_DIGITS-1:0]   onehot;
`ifdef LEADING_ZERO_BLANK_EN
   logic                    zero_above;
`endif

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0:    decode = 7'b1000000;
         4'h1:    decode = 7'b1111001;
         4'h2:    decode = 7'b0100100;
         4'h3:    decode = 7'b0110000;
         4'h4:    decode = 7'b0011001;
         4'h5:    decode = 7'b0010010;
         4'h6:    decode = 7'b0000010;
         4'h7:    decode = 7'b1111000;
         4'h8:    decode = 7'b0000000;
         4'h9:    decode = 7'b0011000;
         4'hA:    decode = 7'b0001000;
         4'hB:    decode = 7'b0000011;
         4'hC:    decode = 7'b1000110;
         4'hD:    decode = 7'b0100001;
         4'hE:    decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      // slot counter and digit index
      wrap      = (cnt_q == CNT_MAX);
      frame_end = wrap && (dig_q == DIG_MAX);
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      dig_d     = dig_q;
      if (wrap) dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;

      state_d = state_q;
      case (state_q)
         ST_GAP:   if (cnt_d >= CNT_DEAD) state_d = ST_DRIVE;
         ST_DRIVE: if (wrap && DEAD_CYCLES != 0) state_d = ST_GAP;
         default:  state_d = ST_RESET;
      endcase

      // pending -> display transfer happens before a same-cycle load
      // overwrites pending, so a boundary load keeps the flag set.
      disp_val_d  = disp_val_q;
      disp_dp_d   = disp_dp_q;
      pend_val_d  = pend_val_q;
      pend_dp_d   = pend_dp_q;
      pend_flag_d = pend_flag_q;
      if (frame_end && pend_flag_q) begin
         disp_val_d  = pend_val_q;
         disp_dp_d   = pend_dp_q;
         pend_flag_d = 1'b0;
      end
      if (load) begin
         pend_val_d  = value;
         pend_dp_d   = dp_mask;
         pend_flag_d = 1'b1;
      end

      nib    = 4'h0;
      dp_sel = 1'b0;
      onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dig_q == DIG_W'(i)) begin
            nib       = disp_val_q[4*i +: 4];
            dp_sel    = disp_dp_q[i];
            onehot[i] = 1'b1;
         end
      end

      lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      // walk from the most significant digit down while nibbles stay zero
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (disp_val_q[4*i +: 4] == 4'h0);
         if ((dig_q == DIG_W'(i)) && zero_above) lz_blank = 1'b1;
      end
`endif

      seg_d    = 7'h7F;
      dp_n_d   = 1'b1;
      dig_en_d = EN_OFF;
      if (!blank && state_q == ST_DRIVE) begin
         seg_d    = lz_blank ? 7'h7F : decode(nib);
         dp_n_d   = ~dp_sel;
         dig_en_d = DIGIT_ACTIVE_LOW ? ~onehot : onehot;
      end

      // delay by one so the pulse lines up with the new frame's first output
      bnd_d        = frame_end;
      frame_done_d = bnd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         dig_q        <= '0;
         state_q      <= ST_RESET;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_flag_q  <= 1'b0;
         bnd_q        <= 1'b0;
         seg_q        <= 7'h7F;
         dp_n_q       <= 1'b1;
         dig_en_q     <= EN_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         state_q      <= state_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_flag_q  <= pend_flag_d;
         bnd_q        <= bnd_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
         dig_en_q     <= dig_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign segments   = seg_q;
   assign dp_n       = dp_n_q;
   assign digit_en   = dig_en_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2,
// active-low digit enables. A reference model pushes the expected output word
// {segments, dp_n, digit_en, frame_done} for each clock edge into a queue;
// each test pops and compares it one cycle later, plus a few fixed checks.
module tb_seg7_scan_driver;
   localparam int ND = 4;
   localparam int SD = 8;
   localparam int DC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic [6:0]  segments;
   logic        dp_n;
   logic [3:0]  digit_en;
   logic        frame_done;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .DIGIT_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
      .load(load), .blank(blank), .segments(segments), .dp_n(dp_n),
      .digit_en(digit_en), .frame_done(frame_done)
   );

   int checks = 0;
   int errors = 0;
   logic [12:0] exp_q[$];

   int          m_cnt, m_dig;
   logic [15:0] m_disp_val, m_pend_val;
   logic [3:0]  m_disp_dp, m_pend_dp;
   logic        m_pflag, m_bnd;

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_dig = 0;
      m_disp_val = '0; m_pend_val = '0; m_disp_dp = '0; m_pend_dp = '0;
      m_pflag = 1'b0; m_bnd = 1'b0;
      exp_q.delete();
   endtask

   // Called with the inputs for the coming edge already applied.
   task automatic model_step();
      logic [6:0] s;
      logic       dpn;
      logic [3:0] en;
      s = 7'h7F; dpn = 1'b1; en = 4'hF;
      if (!blank && m_cnt >= DC) begin
         s = ref_seg(m_disp_val[4*m_dig +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
         if (m_dig > 0 && (m_disp_val >> (4*m_dig)) == 16'h0) s = 7'h7F;
`endif
         dpn = ~m_disp_dp[m_dig];
         en  = ~(4'b0001 << m_dig);
      end
      exp_q.push_back({s, dpn, en, m_bnd});
      m_bnd = (m_cnt == SD-1) && (m_dig == ND-1);
      if (m_bnd && m_pflag) begin
         m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_pflag = 1'b0;
      end
      if (load) begin
         m_pend_val = value; m_pend_dp = dp_mask; m_pflag = 1'b1;
      end
      if (m_cnt == SD-1) begin
         m_cnt = 0;
         m_dig = (m_dig + 1) % ND;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({segments, dp_n, digit_en, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h",
                  {segments, dp_n, digit_en, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_scan_start();
      logic [12:0] obs, exp_w;
      int first_fd;
      first_fd = -1;
      for (int i = 1; i <= 40; i++) begin
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL scan_start cyc %0d: got %h expected %h", i, obs, exp_w);
         end
         if (frame_done && first_fd < 0) first_fd = i;
         if (i == 2) begin
            checks++;
            if (digit_en !== 4'hF) begin
               errors++;
               $display("FAIL scan_gap: digit_en got %b expected 1111", digit_en);
            end
         end
         if (i == 3) begin
            checks++;
            if ({segments, digit_en} !== {7'b1000000, 4'b1110}) begin
               errors++;
               $display("FAIL scan_digit0: got %b %b expected 1000000 1110", segments, digit_en);
            end
         end
      end
      checks++;
      if (first_fd != 33) begin
         errors++;
         $display("FAIL first_frame_done: got cycle %0d expected 33", first_fd);
      end
   endtask

   task automatic test_load();
      logic [12:0] obs, exp_w;
      int seen_a_dp;
      seen_a_dp = 0;
      for (int i = 0; i < 80; i++) begin
         load = (i == 5);
         value = (i == 5) ? 16'h3A7F : 16'h0;
         dp_mask = (i == 5) ? 4'b0100 : 4'b0;
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL load cyc %0d: got %h expected %h", i, obs, exp_w);
         end
         if (obs[12:1] == {7'b0001000, 1'b0, 4'b1011}) seen_a_dp++;
      end
      load = 1'b0;
      checks++;
      if (seen_a_dp < 6) begin
         errors++;
         $display("FAIL load_digit2_dp: got %0d cycles expected at least 6", seen_a_dp);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] obs, exp_w;
      int seen_one, phase;
      seen_one = 0; phase = 0;
      for (int i = 0; i < 90; i++) begin
         load = 1'b0;
         if (phase == 0 && m_cnt == 1 && m_dig == 0) begin
            load = 1'b1; value = 16'h1111; dp_mask = 4'b0000; phase = 1;
         end else if (phase == 1 && m_cnt == 3 && m_dig == 1) begin
            load = 1'b1; value = 16'h2222; dp_mask = 4'b0001; phase = 2;
         end
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs, exp_w);
         end
         if (segments == 7'b1111001) seen_one++;
      end
      load = 1'b0;
      checks++;
      if (seen_one != 0 || phase != 2) begin
         errors++;
         $display("FAIL back_to_back_last_wins: digit1 cycles %0d phase %0d expected 0 and 2",
                  seen_one, phase);
      end
   endtask

   task automatic test_boundary_load();
      logic [12:0] obs, exp_w;
      int seen4, seen5, phase;
      seen4 = 0; seen5 = 0; phase = 0;
      for (int i = 0; i < 110; i++) begin
         load = 1'b0;
         if (phase == 0 && m_cnt == 2 && m_dig == 1) begin
            load = 1'b1; value = 16'h4444; dp_mask = 4'b1000; phase = 1;
         end else if (phase == 1 && m_cnt == SD-1 && m_dig == ND-1) begin
            load = 1'b1; value = 16'h5555; dp_mask = 4'b0010; phase = 2;
         end
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL boundary_load cyc %0d: got %h expected %h", i, obs, exp_w);
         end
         if (segments == 7'b0011001) seen4++;
         if (segments == 7'b0010010) seen5++;
      end
      load = 1'b0;
      checks++;
      if (seen4 != 24 || seen5 == 0) begin
         errors++;
         $display("FAIL boundary_load_frames: got %0d/%0d cycles of 4/5 expected 24/nonzero",
                  seen4, seen5);
      end
   endtask

   task automatic test_blank();
      logic [12:0] obs, exp_w;
      int start, dark, fds;
      start = -1; dark = 0; fds = 0;
      for (int i = 0; i < 70; i++) begin
         if (start < 0 && m_cnt == 3) start = i;
         blank = (start >= 0 && i < start + 10);
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL blank cyc %0d: got %h expected %h", i, obs, exp_w);
         end
         if (blank && obs[12:1] == {7'h7F, 1'b1, 4'hF}) dark++;
         if (frame_done) fds++;
      end
      blank = 1'b0;
      checks++;
      if (dark != 10 || fds < 2) begin
         errors++;
         $display("FAIL blank_window: dark %0d frame_done %0d expected 10 and >=2", dark, fds);
      end
   endtask

   task automatic test_reset_mid();
      logic [12:0] obs, exp_w;
      for (int i = 0; i < 40; i++) begin
         if (m_dig == 2 && m_cnt == 4) break;
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL reset_mid_pre cyc %0d: got %h expected %h", i, obs, exp_w);
         end
      end
      checks++;
      if (digit_en !== 4'b1011) begin
         errors++;
         $display("FAIL reset_mid_setup: digit_en got %b expected 1011", digit_en);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({segments, dp_n, digit_en, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_async: got %h expected %h",
                  {segments, dp_n, digit_en, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL reset_mid_post cyc %0d: got %h expected %h", i, obs, exp_w);
         end
         if (i == 3) begin
            checks++;
            if ({segments, digit_en} !== {7'b1000000, 4'b1110}) begin
               errors++;
               $display("FAIL reset_mid_restart: got %b %b expected 1000000 1110",
                        segments, digit_en);
            end
         end
      end
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   task automatic test_lzb();
      logic [12:0] obs, exp_w;
      for (int i = 0; i < 140; i++) begin
         load = (i == 1 || i == 70);
         value = (i == 1) ? 16'h0050 : 16'h0000;
         dp_mask = 4'b0000;
         model_step();
         @(posedge clk); #1;
         obs = {segments, dp_n, digit_en, frame_done};
         exp_w = exp_q.pop_front();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL lzb cyc %0d: got %h expected %h", i, obs, exp_w);
         end
      end
      load = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_scan_start();
      test_load();
      test_back_to_back();
      test_boundary_load();
      test_blank();
      test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
      test_lzb();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
